// File: rtl/thumb_decode_if.sv
// Fetch -> decode -> execute handshake bundle for the Thumb-16 decode stage.
interface thumb_decode_if #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_SEL_W = 4
);
  // Fetch side
  logic                 in_valid;
  logic                 in_ready;
  logic [15:0]          instruction;
  logic [DATA_W-1:0]    PC_in;
  // Execute side
  logic                 out_valid;
  logic                 out_ready;
  logic [4:0]           uop;
  logic                 num_to_rhs;
  logic [DATA_W-1:0]    num;
  logic [DATA_W-1:0]    PC_out;
  logic [REG_SEL_W-1:0] sel_p0;
  logic [REG_SEL_W-1:0] sel_p1;
  logic [REG_SEL_W-1:0] sel_in;
  logic [3:0]           branch_cond;
  logic                 explose;

  // The decode stage itself
  modport master (
    input  in_valid, instruction, PC_in, out_ready,
    output in_ready, out_valid, uop, num_to_rhs, num, PC_out,
           sel_p0, sel_p1, sel_in, branch_cond, explose
  );

  // Surrounding pipeline (fetch producer / execute consumer)
  modport slave (
    output in_valid, instruction, PC_in, out_ready,
    input  in_ready, out_valid, uop, num_to_rhs, num, PC_out,
           sel_p0, sel_p1, sel_in, branch_cond, explose
  );
endinterface

// File: rtl/thumb_decode_stage.sv
// Pipelined Thumb-16 decode stage: one halfword per accepted transfer,
// registered micro-op bundle, BL prefix/suffix pairing, stall and flush.
module thumb_decode_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_SEL_W  = 4,
  parameter int unsigned SUPPORT_BL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  thumb_decode_if.master  bus
);

  typedef enum logic [4:0] {
    UOP_B   = 5'd0,
    UOP_ADD = 5'd1,
    UOP_SUB = 5'd2,
    UOP_EOR = 5'd4,
    UOP_CMP = 5'd5,
    UOP_LSL = 5'd6,
    UOP_MOV = 5'd8,
    UOP_STR = 5'd9,
    UOP_LDR = 5'd10,
    UOP_BL  = 5'd11
  } uop_e;

  typedef enum logic {
    ST_IDLE,
    ST_BL_WAIT
  } bl_state_e;

  function automatic logic [REG_SEL_W-1:0] rsel(input logic [2:0] r);
    return REG_SEL_W'(r);
  endfunction

  bl_state_e            state_q, state_d;
  logic [10:0]          hi11_q, hi11_d;
  logic [DATA_W-1:0]    bl_pc_q, bl_pc_d;

  logic                 out_valid_q, out_valid_d;
  uop_e                 uop_q, uop_d;
  logic                 rhs_q, rhs_d;
  logic [DATA_W-1:0]    num_q, num_d;
  logic [DATA_W-1:0]    pc_q, pc_d;
  logic [REG_SEL_W-1:0] p0_q, p0_d, p1_q, p1_d, in_q, in_d;
  logic [3:0]           cond_q, cond_d;
  logic                 exp_q, exp_d;

  uop_e                 dec_uop;
  logic                 dec_rhs;
  logic [DATA_W-1:0]    dec_num;
  logic [DATA_W-1:0]    dec_pc;
  logic [REG_SEL_W-1:0] dec_p0, dec_p1, dec_in;
  logic [3:0]           dec_cond;
  logic                 dec_exp;
  logic                 dec_emit;
  logic                 dec_start;

  logic [15:0]          ins;
  logic                 accept;

  assign ins          = bus.instruction;
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid   = out_valid_q;
  assign bus.uop         = uop_q;
  assign bus.num_to_rhs  = rhs_q;
  assign bus.num         = num_q;
  assign bus.PC_out      = pc_q;
  assign bus.sel_p0      = p0_q;
  assign bus.sel_p1      = p1_q;
  assign bus.sel_in      = in_q;
  assign bus.branch_cond = cond_q;
  assign bus.explose     = exp_q;

  // Decode the offered halfword into a candidate bundle (used only on accept)
  always_comb begin
    dec_uop   = UOP_B;
    dec_rhs   = 1'b0;
    dec_num   = '0;
    dec_pc    = bus.PC_in;
    dec_p0    = '0;
    dec_p1    = '0;
    dec_in    = '0;
    dec_cond  = 4'hF;
    dec_exp   = 1'b0;
    dec_emit  = 1'b1;
    dec_start = 1'b0;
    if (state_q == ST_BL_WAIT) begin
      if (ins[15:11] == 5'b11111) begin
        dec_uop  = UOP_BL;
        dec_cond = 4'hE;
        dec_num  = DATA_W'($signed({hi11_q, ins[10:0]})) << 1;
        dec_pc   = bl_pc_q;
      end else begin
        dec_exp = 1'b1;
      end
    end else begin
      casez (ins[15:11])
        5'b00000: begin
          dec_in = rsel(ins[2:0]);
          if (ins[10:6] == 5'd0) begin
            dec_uop = UOP_MOV;
            dec_p0  = rsel(ins[5:3]);
          end else begin
            dec_uop = UOP_LSL;
            dec_rhs = 1'b1;
            dec_num = DATA_W'(ins[10:6]);
            dec_p1  = rsel(ins[5:3]);
          end
        end
        5'b00011: begin
          dec_uop = ins[9] ? UOP_SUB : UOP_ADD;
          dec_p1  = rsel(ins[5:3]);
          dec_in  = rsel(ins[2:0]);
          if (ins[10]) begin
            dec_rhs = 1'b1;
            dec_num = DATA_W'(ins[8:6]);
          end else begin
            dec_p0 = rsel(ins[8:6]);
          end
        end
        5'b001??: begin
          dec_rhs = 1'b1;
          dec_num = DATA_W'(ins[7:0]);
          case (ins[12:11])
            2'b00: begin dec_uop = UOP_MOV; dec_in = rsel(ins[10:8]); end
            2'b01: begin dec_uop = UOP_CMP; dec_p1 = rsel(ins[10:8]); end
            2'b10: begin
              dec_uop = UOP_ADD;
              dec_p1  = rsel(ins[10:8]);
              dec_in  = rsel(ins[10:8]);
            end
            default: begin
              dec_uop = UOP_SUB;
              dec_p1  = rsel(ins[10:8]);
              dec_in  = rsel(ins[10:8]);
            end
          endcase
        end
        5'b01000: begin
          if (ins[10:6] == 5'b00001) begin
            dec_uop = UOP_EOR;
            dec_p0  = rsel(ins[2:0]);
            dec_in  = rsel(ins[2:0]);
            dec_p1  = rsel(ins[5:3]);
          end else begin
            dec_exp = 1'b1;
          end
        end
        5'b0110?: begin
          dec_uop = ins[11] ? UOP_LDR : UOP_STR;
          dec_rhs = 1'b1;
          dec_num = DATA_W'({ins[10:6], 2'b00});
          dec_p1  = rsel(ins[5:3]);
          if (ins[11]) dec_in = rsel(ins[2:0]);
          else         dec_p0 = rsel(ins[2:0]);
        end
        5'b1101?: begin
          if (ins[11:9] == 3'b111) begin
            dec_exp = 1'b1;
          end else begin
            dec_cond = ins[11:8];
            dec_num  = DATA_W'($signed(ins[7:0])) << 1;
          end
        end
        5'b11100: begin
          dec_cond = 4'hE;
          dec_num  = DATA_W'($signed(ins[10:0])) << 1;
        end
        5'b11110: begin
          if (SUPPORT_BL != 0) begin
            dec_emit  = 1'b0;
            dec_start = 1'b1;
          end else begin
            dec_exp = 1'b1;
          end
        end
        default: dec_exp = 1'b1;
      endcase
    end
  end

  // Next state: drain/hold the output register, load on accept, clear on flush
  always_comb begin
    state_d     = state_q;
    hi11_d      = hi11_q;
    bl_pc_d     = bl_pc_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    uop_d       = uop_q;
    rhs_d       = rhs_q;
    num_d       = num_q;
    pc_d        = pc_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    in_d        = in_q;
    cond_d      = cond_q;
    exp_d       = exp_q;
    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      uop_d       = UOP_B;
      rhs_d       = 1'b0;
      num_d       = '0;
      pc_d        = '0;
      p0_d        = '0;
      p1_d        = '0;
      in_d        = '0;
      cond_d      = 4'hF;
      exp_d       = 1'b0;
    end else if (accept) begin
      // A BL prefix only arms the pair state; the output register simply drains.
      if (dec_start) begin
        state_d = ST_BL_WAIT;
        hi11_d  = ins[10:0];
        bl_pc_d = bus.PC_in;
      end else begin
        state_d = ST_IDLE;
      end
      if (dec_emit) begin
        out_valid_d = 1'b1;
        uop_d       = dec_uop;
        rhs_d       = dec_rhs;
        num_d       = dec_num;
        pc_d        = dec_pc;
        p0_d        = dec_p0;
        p1_d        = dec_p1;
        in_d        = dec_in;
        cond_d      = dec_cond;
        exp_d       = dec_exp;
      end
    end
  end

  // State and output bundle registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hi11_q      <= '0;
      bl_pc_q     <= '0;
      out_valid_q <= 1'b0;
      uop_q       <= UOP_B;
      rhs_q       <= 1'b0;
      num_q       <= '0;
      pc_q        <= '0;
      p0_q        <= '0;
      p1_q        <= '0;
      in_q        <= '0;
      cond_q      <= 4'hF;
      exp_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi11_q      <= hi11_d;
      bl_pc_q     <= bl_pc_d;
      out_valid_q <= out_valid_d;
      uop_q       <= uop_d;
      rhs_q       <= rhs_d;
      num_q       <= num_d;
      pc_q        <= pc_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      in_q        <= in_d;
      cond_q      <= cond_d;
      exp_q       <= exp_d;
    end
  end

endmodule

// File: tb/tb_thumb_decode_stage.sv
// Testbench for thumb_decode_stage: vector table, hand-written sequences
// for stall/BL/flush/reset, then randomized traffic against a reference model.
module tb_thumb_decode_stage;

  typedef struct packed {
    logic [4:0]  uop;
    logic        rhs;
    logic [31:0] num;
    logic [31:0] pc;
    logic [3:0]  p0;
    logic [3:0]  p1;
    logic [3:0]  sin;
    logic [3:0]  cond;
    logic        exp;
  } bundle_t;

  typedef struct {
    logic [15:0] w;
    bundle_t     e;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  thumb_decode_if #(.DATA_W(32), .REG_SEL_W(4)) bus ();

  thumb_decode_stage #(.DATA_W(32), .REG_SEL_W(4), .SUPPORT_BL(1)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t    tbl[$];
  bundle_t expq[$];
  bit          bl_wait;
  logic [10:0] bl_hi;
  logic [31:0] bl_pc;

  function automatic bundle_t mk(input logic [4:0] u, input logic r, input logic [31:0] n,
                                 input logic [31:0] pc, input logic [3:0] p0, input logic [3:0] p1,
                                 input logic [3:0] si, input logic [3:0] cd, input logic x);
    bundle_t b;
    b.uop = u; b.rhs = r; b.num = n; b.pc = pc;
    b.p0 = p0; b.p1 = p1; b.sin = si; b.cond = cd; b.exp = x;
    return b;
  endfunction

  function automatic bundle_t cur();
    return mk(bus.uop, bus.num_to_rhs, bus.num, bus.PC_out, bus.sel_p0, bus.sel_p1,
              bus.sel_in, bus.branch_cond, bus.explose);
  endfunction

  // Reference decode from the instruction-set rules, using plain integer arithmetic
  function automatic bundle_t ref_decode(input logic [15:0] w, input logic [31:0] pc,
                                         input bit waiting, input logic [10:0] hi,
                                         input logic [31:0] hpc, output bit emit, output bit start);
    bundle_t b;
    int op5, rlo, rmid, rhi, r8, s;
    op5 = int'(w[15:11]); rlo = int'(w[2:0]); rmid = int'(w[5:3]);
    rhi = int'(w[8:6]); r8 = int'(w[10:8]);
    b = mk(0, 0, 0, pc, 0, 0, 0, 4'hF, 0);
    emit = 1; start = 0;
    if (waiting) begin
      if (op5 == 31) begin
        s = int'(hi) * 2048 + int'(w[10:0]);
        if (s >= (1 << 21)) s -= (1 << 22);
        b.uop = 11; b.cond = 4'hE; b.num = 32'(s * 2); b.pc = hpc;
      end else b.exp = 1;
      return b;
    end
    if (op5 == 0) begin
      if (w[10:6] == 0) begin b.uop = 8; b.p0 = 4'(rmid); b.sin = 4'(rlo); end
      else begin b.uop = 6; b.rhs = 1; b.num = 32'(w[10:6]); b.p1 = 4'(rmid); b.sin = 4'(rlo); end
    end else if (op5 == 3) begin
      b.uop = (w[9] == 1'b1) ? 5'd2 : 5'd1;
      b.p1 = 4'(rmid); b.sin = 4'(rlo);
      if (w[10]) begin b.rhs = 1; b.num = 32'(rhi); end
      else b.p0 = 4'(rhi);
    end else if (op5 >= 4 && op5 <= 7) begin
      b.rhs = 1; b.num = 32'(w[7:0]);
      case (op5)
        4: begin b.uop = 8; b.sin = 4'(r8); end
        5: begin b.uop = 5; b.p1 = 4'(r8); end
        6: begin b.uop = 1; b.p1 = 4'(r8); b.sin = 4'(r8); end
        default: begin b.uop = 2; b.p1 = 4'(r8); b.sin = 4'(r8); end
      endcase
    end else if (int'(w[15:6]) == 257) begin
      b.uop = 4; b.p0 = 4'(rlo); b.sin = 4'(rlo); b.p1 = 4'(rmid);
    end else if (op5 == 12 || op5 == 13) begin
      b.uop = (op5 == 13) ? 5'd10 : 5'd9;
      b.rhs = 1; b.num = 32'(int'(w[10:6]) * 4); b.p1 = 4'(rmid);
      if (op5 == 13) b.sin = 4'(rlo); else b.p0 = 4'(rlo);
    end else if ((op5 == 26 || op5 == 27) && int'(w[11:8]) < 14) begin
      s = int'(w[7:0]); if (s >= 128) s -= 256;
      b.cond = w[11:8]; b.num = 32'(s * 2);
    end else if (op5 == 28) begin
      s = int'(w[10:0]); if (s >= 1024) s -= 2048;
      b.cond = 4'hE; b.num = 32'(s * 2);
    end else if (op5 == 30) begin
      emit = 0; start = 1;
    end else begin
      b.exp = 1;
    end
    return b;
  endfunction

  task automatic chk(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, a, e);
    end
  endtask

  task automatic chk_b(input string nm, input bundle_t e);
    bundle_t a;
    a = cur();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got uop=%0d rhs=%0b num=%h pc=%h p0=%0d p1=%0d in=%0d cond=%h exp=%0b want uop=%0d rhs=%0b num=%h pc=%h p0=%0d p1=%0d in=%0d cond=%h exp=%0b",
               nm, a.uop, a.rhs, a.num, a.pc, a.p0, a.p1, a.sin, a.cond, a.exp,
               e.uop, e.rhs, e.num, e.pc, e.p0, e.p1, e.sin, e.cond, e.exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] w, input logic [31:0] pc, input logic ordy);
    bus.in_valid = iv; bus.instruction = w; bus.PC_in = pc; bus.out_ready = ordy;
  endtask

  task automatic add(input logic [15:0] w, input logic [4:0] u, input logic r, input logic [31:0] n,
                     input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] si,
                     input logic [3:0] cd, input logic x);
    vec_t v;
    v.w = w;
    v.e = mk(u, r, n, 32'h1000 + 32'(2 * tbl.size()), p0, p1, si, cd, x);
    tbl.push_back(v);
  endtask

  task automatic add_x(input logic [15:0] w);
    add(w, 0, 0, 0, 0, 0, 0, 4'hF, 1);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 10))
      0: w[15:11] = 5'b00000;
      1: w[15:11] = 5'b00011;
      2: w[15:13] = 3'b001;
      3: w[15:6]  = 10'b0100000001;
      4: w[15:12] = 4'b0110;
      5: w[15:12] = 4'b1101;
      6: w[15:11] = 5'b11100;
      7, 8: w[15:11] = 5'b11110;
      9: w[15:11] = 5'b11111;
      default: ;
    endcase
    return w;
  endfunction

  bundle_t zero_b;

  initial begin
    bundle_t b;
    bit em, st, iv, ordy, fl;
    logic [15:0] w;
    logic [31:0] pc;

    zero_b = mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 0);
    reset = 1'b1; flush = 1'b0;
    drive(0, 16'h0, 32'h0, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_in_ready", bus.in_ready, 1'b1);
    chk_b("reset_bundle", zero_b);

    // Single-instruction vectors, applied back-to-back with out_ready=1
    add(16'h188B, 1, 0, 0, 2, 1, 3, 4'hF, 0);
    add(16'h1A8B, 2, 0, 0, 2, 1, 3, 4'hF, 0);
    add(16'h1C8B, 1, 1, 2, 0, 1, 3, 4'hF, 0);
    add(16'h1E8B, 2, 1, 2, 0, 1, 3, 4'hF, 0);
    add(16'h257F, 8, 1, 32'h7F, 0, 0, 5, 4'hF, 0);
    add(16'h2A10, 5, 1, 32'h10, 0, 2, 0, 4'hF, 0);
    add(16'h3305, 1, 1, 5, 0, 3, 3, 4'hF, 0);
    add(16'h3B01, 2, 1, 1, 0, 3, 3, 4'hF, 0);
    add(16'h0048, 6, 1, 1, 0, 1, 0, 4'hF, 0);
    add(16'h0008, 8, 0, 0, 1, 0, 0, 4'hF, 0);
    add(16'h4051, 4, 0, 0, 1, 2, 1, 4'hF, 0);
    add(16'h6051, 9, 1, 4, 1, 2, 0, 4'hF, 0);
    add(16'h6888, 10, 1, 8, 0, 1, 0, 4'hF, 0);
    add(16'hD1FE, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, 4'h1, 0);
    add(16'hD07F, 0, 0, 32'h0000_00FE, 0, 0, 0, 4'h0, 0);
    add(16'hE7FE, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, 4'hE, 0);
    add_x(16'hDE00);
    add_x(16'hDF00);
    add_x(16'hF800);
    add_x(16'h4000);
    add_x(16'h0800);
    foreach (tbl[i]) begin
      drive(1, tbl[i].w, tbl[i].e.pc, 1);
      @(negedge clk);
      chk($sformatf("vec_valid_%04h", tbl[i].w), bus.out_valid, 1'b1);
      chk_b($sformatf("vec_%04h", tbl[i].w), tbl[i].e);
    end
    drive(0, 16'h0, 32'h0, 1);
    @(negedge clk);
    chk("vec_drained", bus.out_valid, 1'b0);

    // Back-to-back MOV then LDR
    drive(1, 16'h257F, 32'h300, 1);
    @(negedge clk);
    chk_b("b2b_mov", mk(8, 1, 32'h7F, 32'h300, 0, 0, 5, 4'hF, 0));
    drive(1, 16'h6888, 32'h302, 1);
    #1 chk("b2b_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    chk("b2b_ldr_valid", bus.out_valid, 1'b1);
    chk_b("b2b_ldr", mk(10, 1, 8, 32'h302, 0, 1, 0, 4'hF, 0));
    drive(0, 16'h0, 32'h0, 1);
    @(negedge clk);
    chk("b2b_drained", bus.out_valid, 1'b0);

    // Stall: bundle held for 3 cycles, in_ready low, new word not taken
    drive(1, 16'hD1FE, 32'h200, 0);
    @(negedge clk);
    for (int unsigned k = 0; k < 3; k++) begin
      drive(1, 16'h188B, 32'h202, 0);
      #1 chk("stall_in_ready", bus.in_ready, 1'b0);
      chk("stall_valid", bus.out_valid, 1'b1);
      chk_b("stall_hold", mk(0, 0, 32'hFFFF_FFFC, 32'h200, 0, 0, 0, 4'h1, 0));
      @(negedge clk);
    end
    drive(1, 16'h188B, 32'h202, 1);
    #1 chk("stall_release_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    chk_b("stall_next", mk(1, 0, 0, 32'h202, 2, 1, 3, 4'hF, 0));
    drive(0, 16'h0, 32'h0, 1);
    @(negedge clk);

    // BL pair with idle gap
    drive(1, 16'hF7FF, 32'h100, 1);
    @(negedge clk);
    chk("bl_prefix_no_bundle", bus.out_valid, 1'b0);
    drive(0, 16'h0, 32'h0, 1);
    @(negedge clk);
    chk("bl_gap1", bus.out_valid, 1'b0);
    @(negedge clk);
    chk("bl_gap2", bus.out_valid, 1'b0);
    drive(1, 16'hFFFE, 32'h102, 1);
    @(negedge clk);
    chk("bl_valid", bus.out_valid, 1'b1);
    chk_b("bl_bundle", mk(11, 0, 32'hFFFF_FFFC, 32'h100, 0, 0, 0, 4'hE, 0));
    drive(0, 16'h0, 32'h0, 1);
    @(negedge clk);
    chk("bl_single", bus.out_valid, 1'b0);

    // Flush during BL_WAIT discards the suffix; a later suffix is an orphan
    drive(1, 16'hF7FF, 32'h400, 1);
    @(negedge clk);
    drive(1, 16'hFFFE, 32'h402, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_valid", bus.out_valid, 1'b0);
    chk_b("flush_bundle", zero_b);
    drive(1, 16'hFFFE, 32'h404, 1);
    @(negedge clk);
    chk("flush_orphan_valid", bus.out_valid, 1'b1);
    chk_b("flush_orphan", mk(0, 0, 0, 32'h404, 0, 0, 0, 4'hF, 1));

    // Reset while a bundle is pending
    drive(1, 16'h188B, 32'h500, 0);
    @(negedge clk);
    chk("rst_pre_valid", bus.out_valid, 1'b1);
    drive(0, 16'h0, 32'h0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk_b("rst_bundle", zero_b);

    // Randomized traffic against the reference model
    bl_wait = 0; bl_hi = '0; bl_pc = '0;
    for (int unsigned c = 0; c < 3000; c++) begin
      chk("rnd_valid", bus.out_valid, expq.size() != 0);
      if (bus.out_valid && expq.size() != 0) chk_b("rnd_bundle", expq[0]);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 63) == 0);
      w    = rand_instr();
      pc   = $urandom & 32'hFFFF_FFFE;
      drive(iv, w, pc, ordy);
      flush = fl;
      #1 chk("rnd_in_ready", bus.in_ready, (expq.size() == 0) || ordy);
      if (fl) begin
        expq.delete();
        bl_wait = 0;
      end else begin
        if (expq.size() != 0 && ordy) void'(expq.pop_front());
        if (iv && ((expq.size() == 0) || ordy)) begin
          b = ref_decode(w, pc, bl_wait, bl_hi, bl_pc, em, st);
          if (st) begin
            bl_wait = 1; bl_hi = w[10:0]; bl_pc = pc;
          end else begin
            bl_wait = 0;
            if (em) expq.push_back(b);
          end
        end
      end
      @(negedge clk);
    end
    flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
